dct2_row_sequencer: RTL and testbench
=====================================

Name: dct2_row_sequencer

Overview:
- Streams one NxN residual block, row by row, through the combinational 1D DCT-II core (sizes 4/8/16/32).
- Per block: accepts a size configuration, then feeds exactly N rows to the core with a valid/ready handshake, registers each core result and emits it downstream, flagging the final row.
- Sits between the block-fetch front end and the transpose buffer of the 2D transform.

Parameters:
- W, 16: sample width in bits; core vector width is 32*W.
- LANES, 32: lanes per core vector; fixed by the core.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  block configuration offered
- cfg_ready  out  1  sequencer idle, config accepted
- cfg_size  in  2  00=4, 01=8, 10=16, 11=32 point
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted this cycle when both high
- in_data  in  512  row samples; lane k at bits [511-16k -: 16]
- core_x  out  512  registered row to core X_test input
- core_n  out  2  latched size to core N input
- core_y  in  512  combinational core result for core_x
- out_valid  out  1  coefficient row valid
- out_ready  in  1  downstream accepts
- out_data  out  512  coefficient row, same lane packing
- out_last  out  1  qualifies final row of block
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n low at a clk edge) values:
  - state IDLE
  - all counters 0
  - s1_valid, out_valid, out_last = 0
  - core_x, out_data = 0
  - core_n = 00
  - cfg_ready = 1, in_ready = 0, busy = 0
- Reset mid-block discards all in-flight rows with no output.
- Rows per block: R = 4 << size.
- IDLE:
  - cfg_ready = 1.
  - On cfg_valid: latch size into core_n; in_cnt = 0; out_cnt = 0; go to RUN.
- RUN:
  - cfg_ready = 0.
  - in_ready = (in_cnt < R) && (!s1_valid || s2_load).
  - On accept: core_x = in_data with lanes k >= R zeroed; s1_valid = 1; in_cnt increments.
  - When in_cnt reaches R on an accept, go to DRAIN.
- DRAIN:
  - in_ready = 0.
  - On out_valid && out_ready && out_last: go to IDLE, with cfg_ready = 1 the next cycle.
- Pipeline:
  - Stage 1 is core_x / s1_valid; stage 2 is out_data / out_valid.
  - s2_load = s1_valid && (!out_valid || out_ready).
  - On s2_load: out_data = core_y with lanes k >= R zeroed; out_last = (out_cnt == R-1); out_cnt increments.
  - s1_valid clears on s2_load unless a new row is accepted in the same cycle.
  - out_valid clears on out_ready when no s2_load occurs that cycle.
- Timing:
  - Latency from in accept to out_valid is 2 cycles.
  - Sustained throughput is 1 row/cycle when out_ready is held high.
- Backpressure:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - With out_ready low, at most 2 rows are in flight; in_ready then drops.
- Config:
  - cfg_valid is ignored unless in IDLE.
  - core_n is constant from config accept until return to IDLE.
- Rows offered before config are not accepted (in_ready = 0 in IDLE).
- Same-cycle events:
  - Final input accept with a simultaneous s2_load is legal.
  - A new config in the same cycle as the last output handshake is not accepted; it is taken the following cycle.
- No arithmetic is performed in the sequencer; lane masking is the only data manipulation.

Test Plan:
- Reset then size=00; rows {64,64,64,64} x4 with out_ready=1 -> 4 outputs, each lane0=8 and lanes1..31=0; out_last on 4th only; out_valid first rises 2 cycles after first accept.
- Size=11; 32 rows back-to-back with out_ready=1 -> in_ready continuously 1; 32 outputs on consecutive cycles; out_last on row 31; cfg_ready=1 one cycle after last handshake.
- Size=01 with out_ready toggling 1,0,0,1 -> no row lost or duplicated; out_data stable while stalled; in_ready=0 when 2 rows in flight; 8 outputs in order.
- Size=00 with in_data lanes 4..31 = 0x7FFF -> core_x lanes 4..31 = 0; out_data lanes 4..31 = 0.
- cfg_valid pulsed with size=11 during a size=10 block -> ignored; core_n stays 10; exactly 16 outputs.
- rst_n low after 3 of 8 rows accepted -> next cycle out_valid=0, busy=0, cfg_ready=1; a new size=00 block then completes correctly.

Source files
------------

// File: rtl/dct2_row_sequencer.sv
// dct2_row_sequencer
//   Streams one NxN residual block, row by row, through the external
//   combinational 1D DCT-II core (N = 4/8/16/32). A block starts with a size
//   configuration, after which exactly N rows are pushed through a two-stage
//   register pipeline. core_x is the stage-1 register that drives the core.
//   out_data captures the core result as stage 2. out_last marks the final
//   row of the block.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_valid/cfg_ready   block configuration handshake (taken only in IDLE)
//   cfg_size              00=4, 01=8, 10=16, 11=32 point
//   in_valid/in_ready     input row handshake
//   in_data               input row; lane k at bits [VW-1-W*k -: W]
//   core_x, core_n        registered row and latched size driving the core
//   core_y                combinational core result for core_x
//   out_valid/out_ready   coefficient row handshake
//   out_data, out_last    coefficient row (same packing), final-row flag
//   busy                  high whenever a block is in progress
module dct2_row_sequencer #(
   parameter int W     = 16,
   parameter int LANES = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [1:0]           cfg_size,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   in_data,
   output logic [LANES*W-1:0]   core_x,
   output logic [1:0]           core_n,
   input  logic [LANES*W-1:0]   core_y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   out_data,
   output logic                 out_last,
   output logic                 busy
);
   localparam int VW = LANES * W;
   localparam int CW = $clog2(LANES) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] in_cnt, out_cnt, rows;
   logic          vld_p1;
   logic          s2_load, in_acc, last_hs;

   // Lanes at or beyond the block size carry no meaning for an N-point
   // transform and are forced to zero on the way in and on the way out.
   function automatic logic [VW-1:0] mask_lanes(input logic [VW-1:0] v,
                                                input logic [CW-1:0] n);
      logic [VW-1:0] r;
      r = v;
      for (int k = 0; k < LANES; k++) begin
         if (k >= int'(n)) r[VW-1-W*k -: W] = '0;
      end
      return r;
   endfunction

   assign rows    = CW'(4) << core_n;
   assign s2_load = vld_p1 && (!out_valid || out_ready);
   assign in_acc  = in_valid && in_ready;
   assign last_hs = out_valid && out_ready && out_last;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            busy      = 1'b0;
            if (cfg_valid) state_nxt = RUN;
         end
         RUN: begin
            // A new row may enter stage 1 only if stage 1 is empty or is
            // handing its row to stage 2 in this same cycle.
            in_ready = (in_cnt < rows) && (!vld_p1 || s2_load);
            if (in_valid && in_ready && (in_cnt == rows - CW'(1)))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (last_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Block configuration and row counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_n  <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else if (state == IDLE && cfg_valid) begin
         core_n  <= cfg_size;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         if (in_acc)  in_cnt  <= in_cnt + CW'(1);
         if (s2_load) out_cnt <= out_cnt + CW'(1);
      end
   end

   // ---- stage 1: accepted row registered onto the core input ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         core_x <= '0;
      end else if (in_acc) begin
         core_x <= mask_lanes(in_data, rows);
         vld_p1 <= 1'b1;
      end else if (s2_load) begin
         vld_p1 <= 1'b0;
      end
   end

   // ---- stage 2: core result captured for the downstream handshake ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= mask_lanes(core_y, rows);
         out_last  <= (out_cnt == rows - CW'(1));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dct2_row_sequencer.sv
// tb_dct2_row_sequencer
//   Randomized bench for dct2_row_sequencer. A stand-in core (DC term plus
//   neighbouring-lane differences) answers core_x. A queue-based reference
//   predicts every coefficient row from the rows offered, the block size
//   and the lane-masking rule.
module tb_dct2_row_sequencer;
   localparam int W     = 16;
   localparam int LANES = 32;
   localparam int VW    = W * LANES;

   logic          clk = 1'b0;
   logic          rst_n, cfg_valid, cfg_ready, in_valid, in_ready;
   logic          out_valid, out_ready, out_last, busy;
   logic [1:0]    cfg_size, core_n;
   logic [VW-1:0] in_data, core_x, core_y, out_data;

   always #5 clk = ~clk;

   dct2_row_sequencer #(.W(W), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_size(cfg_size),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_x(core_x), .core_n(core_n), .core_y(core_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lane(input logic [VW-1:0] v, input int k);
      return v[VW-1-16*k -: 16];
   endfunction

   // Keep the first n lanes (the top 16*n bits), clear the rest.
   function automatic logic [VW-1:0] keep(input logic [VW-1:0] v, input int n);
      logic [VW-1:0] m;
      m = ~({VW{1'b1}} >> (16 * n));
      return v & m;
   endfunction

   // Stand-in core: lane0 = (sum of lanes) >>> 5, lane k = x[k-1] - x[k].
   function automatic logic [VW-1:0] mock_core(input logic [VW-1:0] x);
      logic [VW-1:0] y;
      int sum;
      y = '0;
      sum = 0;
      for (int k = 0; k < LANES; k++) sum += int'($signed(lane(x, k)));
      y[VW-1 -: 16] = 16'(sum >>> 5);
      for (int k = 1; k < LANES; k++)
         y[VW-1-16*k -: 16] = lane(x, k-1) - lane(x, k);
      return y;
   endfunction

   always_comb core_y = mock_core(core_x);

   // dmode 0: random lanes; 1: first n random, rest 0x7FFF; 2: lanes0..3 = 64
   function automatic logic [VW-1:0] make_row(input int n, input int dmode);
      logic [VW-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         case (dmode)
            1:       r[VW-1-16*k -: 16] = (k < n) ? 16'($urandom) : 16'h7FFF;
            2:       r[VW-1-16*k -: 16] = (k < 4) ? 16'd64 : 16'd0;
            default: r[VW-1-16*k -: 16] = 16'($urandom);
         endcase
      end
      return r;
   endfunction

   logic [VW-1:0] exp_q[$];
   int            rows_cur = 4;
   int            pushed = 0, popped = 0, cyc = 0;
   int            first_acc_cyc = 0, first_out_cyc = 0, last_out_cyc = 0;
   logic          prev_stall = 1'b0, prev_last = 1'b0, acc_prev = 1'b0;
   logic          smp_in_ready = 1'b0, smp_acc_in = 1'b0, dc8 = 1'b0;
   logic [VW-1:0] prev_data = '0, last_row = '0;
   logic [1:0]    exp_size = 2'd0;

   // Called just after a falling edge with inputs applied; observes the
   // cycle, scores the handshakes due at the next rising edge, and returns
   // at the following falling edge.
   task automatic step();
      logic acc_in, acc_out;
      #1;
      cyc++;
      acc_in       = in_valid && in_ready;
      acc_out      = out_valid && out_ready;
      smp_in_ready = in_ready;
      smp_acc_in   = acc_in && rst_n;
      if (rst_n) begin
         if (acc_prev) chk("core_x", core_x, keep(last_row, rows_cur));
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
         end
         chk("inflight_max", (pushed - popped) <= 2, 1);
         if ((pushed - popped) == 2 && !out_ready) chk("in_ready_full", in_ready, 0);
         if (busy) chk("core_n", core_n, exp_size);
         if (acc_in) begin
            if (pushed == 0) first_acc_cyc = cyc;
            exp_q.push_back(keep(mock_core(keep(in_data, rows_cur)), rows_cur));
            pushed++;
         end
         if (acc_out) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
               chk("out_last", out_last, popped == rows_cur - 1);
               if (dc8) begin
                  chk("dc_lane0", lane(out_data, 0), 16'd8);
                  chk("dc_rest", keep(out_data << 16, 31), 0);
               end
            end
            if (popped == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            popped++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         acc_prev   = acc_in;
         last_row   = in_data;
      end else begin
         prev_stall = 1'b0;
         acc_prev   = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic start_block(input logic [1:0] sz);
      int t;
      t = 0;
      in_valid  = 1'b0;
      cfg_valid = 1'b1;
      cfg_size  = sz;
      while (!cfg_ready && t < 100) begin
         step();
         t++;
      end
      if (t >= 100) chk("cfg_timeout", 1, 0);
      exp_size = sz;
      rows_cur = 4 << sz;
      pushed   = 0;
      popped   = 0;
      step();
      cfg_valid = 1'b0;
   endtask

   // rmode 0: back-to-back, out_ready=1; 1: out_ready 1,0,0,1; 2: random.
   // inject_at >= 0 pulses a size=11 config at that cycle of the block.
   task automatic feed(input int rmode, input int dmode, input int inject_at);
      int sent, t, gaps;
      sent = 0;
      t    = 0;
      gaps = 0;
      while (popped < rows_cur && t < 3000) begin
         in_valid = (sent < rows_cur) && ((rmode == 0) || ($urandom_range(0, 3) != 0));
         in_data  = make_row(rows_cur, dmode);
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((t % 4) == 0) || ((t % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (inject_at >= 0) begin
            cfg_valid = (t == inject_at);
            cfg_size  = 2'd3;
         end
         step();
         if (rmode == 0 && in_valid && !smp_in_ready) gaps++;
         if (smp_acc_in) sent++;
         t++;
      end
      if (t >= 3000) chk("feed_timeout", 1, 0);
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      chk("cfg_ready_after", cfg_ready, 1);
      if (rmode == 0) begin
         chk("b2b_gaps", gaps, 0);
         chk("b2b_span", last_out_cyc - first_out_cyc, rows_cur - 1);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("queue_empty", exp_q.size(), 0);
      chk("rows_out", popped, rows_cur);
   endtask

   task automatic reset_checks(input string pfx);
      #1;
      chk({pfx, "_cfg_ready"}, cfg_ready, 1);
      chk({pfx, "_in_ready"}, in_ready, 0);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_out_valid"}, out_valid, 0);
      chk({pfx, "_out_last"}, out_last, 0);
      chk({pfx, "_core_x"}, core_x, 0);
      chk({pfx, "_out_data"}, out_data, 0);
      chk({pfx, "_core_n"}, core_n, 0);
   endtask

   initial begin
      int sent, t;
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_size  = 2'd0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step();
      rst_n = 1'b1;
      reset_checks("rst");

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = make_row(32, 0);
         step();
         chk("pre_cfg_in_ready", smp_in_ready, 0);
         chk("pre_cfg_out_valid", out_valid, 0);
      end
      in_valid = 1'b0;

      dc8 = 1'b1;
      start_block(2'd0);
      feed(0, 2, -1);
      chk("latency", first_out_cyc - first_acc_cyc, 2);
      dc8 = 1'b0;

      start_block(2'd3);
      feed(0, 0, -1);

      start_block(2'd1);
      feed(1, 0, -1);

      start_block(2'd0);
      feed(2, 1, -1);

      start_block(2'd2);
      feed(2, 0, 5);

      start_block(2'd1);
      sent = 0;
      t    = 0;
      while (sent < 3 && t < 100) begin
         in_valid  = 1'b1;
         in_data   = make_row(rows_cur, 0);
         out_ready = 1'b1;
         step();
         if (smp_acc_in) sent++;
         t++;
      end
      if (t >= 100) chk("mid_rst_timeout", 1, 0);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      rst_n = 1'b1;
      exp_q.delete();
      pushed   = 0;
      popped   = 0;
      exp_size = 2'd0;
      reset_checks("mid_rst");
      out_ready = 1'b1;
      start_block(2'd0);
      feed(2, 0, -1);

      for (int i = 0; i < 4; i++) begin
         start_block(2'($urandom_range(0, 3)));
         feed((i % 2 == 0) ? 2 : 1, i % 2, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
